adder_arbiter: RTL

//  Shares one carry_lookahead_adder #(WIDTH) among NREQ requesters.

---
 rtl/adder_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one carry_lookahead_adder among NREQ requesters.
// Round-robin arbitration picks a winner in IDLE. The winner's operands are
// registered, the sum is captured in CALC, and RESP holds {c_out,sum} and the
// winner's ID until the consumer accepts it.
//
// Optional build macro: ADDER_ARB_STATS_EN adds the op_count/stall_count ports.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   req_valid   [NREQ]        request i presents operands
//   req_ready   [NREQ]        one-hot grant, high only in the accept cycle
//   req_a       [NREQ*WIDTH]  operand A of req i at [i*WIDTH +: WIDTH]
//   req_b       [NREQ*WIDTH]  operand B of req i, same packing
//   req_c       [NREQ]        carry-in of req i
//   rsp_valid   result available
//   rsp_ready   consumer accepts result
//   rsp_id      [IDW]         index of the requester that owns the result
//   rsp_result  [WIDTH+1]     {c_out, sum}
//   op_count    [32]          (stats build) completed response handshakes
//   stall_count [32]          (stats build) RESP cycles with rsp_ready low

// Block carry-lookahead adder: 4-bit lookahead groups, rippled group carries.
module carry_lookahead_adder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int unsigned W  = WIDTH;
    localparam int unsigned GW = 4;
    localparam int unsigned NG = (W + GW - 1) / GW;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] cin_vec;
    logic             grp_in;
    logic             grp_out;

    // Carry out of bit hi, given carry ci into bit lo, as a flat sum of products.
    function automatic logic lookahead(input logic [WIDTH-1:0] gv,
                                       input logic [WIDTH-1:0] pv,
                                       input int unsigned lo,
                                       input int unsigned hi,
                                       input logic ci);
        logic c;
        logic t;
        c = ci;
        for (int unsigned m = lo; m <= hi; m++) c = c & pv[m];
        for (int unsigned j = lo; j <= hi; j++) begin
            t = gv[j];
            for (int unsigned m = j + 1; m <= hi; m++) t = t & pv[m];
            c = c | t;
        end
        return c;
    endfunction

    always_comb begin
        g       = a & b;
        p       = a ^ b;
        cin_vec = '0;
        grp_in  = c_in;
        grp_out = 1'b0;
        for (int unsigned grp = 0; grp < NG; grp++) begin
            for (int unsigned k = 0; k < GW; k++) begin
                if (grp * GW + k < W) begin
                    if (k == 0) cin_vec[grp*GW] = grp_in;
                    else cin_vec[grp*GW+k] = lookahead(g, p, grp * GW, grp * GW + k - 1, grp_in);
                end
            end
            grp_out = lookahead(g, p, grp * GW,
                                (grp * GW + GW - 1 < W) ? grp * GW + GW - 1 : W - 1, grp_in);
            grp_in  = grp_out;
        end
        sum   = p ^ cin_vec;
        c_out = grp_out;
    end
endmodule

module adder_arbiter #(
    parameter  int WIDTH = 64,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_c,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH:0]        rsp_result
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [31:0]           op_count,
    output logic [31:0]           stall_count
`endif
);
    localparam int unsigned NR = NREQ;
    localparam int unsigned W  = WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

    state_t           state;
    state_t           state_next;

    logic [IDW-1:0]   last;
    logic [IDW-1:0]   gnt_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_c;

    logic             found;
    logic [IDW-1:0]   pick;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_c;

    logic [WIDTH-1:0] sum;
    logic             c_out;

    carry_lookahead_adder #(.WIDTH(WIDTH)) u_adder (
        .a     (op_a),
        .b     (op_b),
        .c_in  (op_c),
        .sum   (sum),
        .c_out (c_out)
    );

    // Round-robin search starting just after the last served requester.
    // Only the winner's operand slice is routed toward the registers.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sel_a = '0;
        sel_b = '0;
        sel_c = 1'b0;
        for (int unsigned off = 1; off <= NR; off++) begin
            int unsigned cand;
            cand = (int'(last) + off) % NR;
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = IDW'(cand);
                sel_a = req_a[cand*W +: W];
                sel_b = req_b[cand*W +: W];
                sel_c = req_c[cand];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    req_ready[pick] = 1'b1;
                    state_next      = S_CALC;
                end
            end
            S_CALC: state_next = S_RESP;
            S_RESP: if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last       <= IDW'(NR - 1);
            gnt_id     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_c       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        op_c   <= sel_c;
                        gnt_id <= pick;
                    end
                end
                S_CALC: begin
                    rsp_result <= {c_out, sum};
                    rsp_id     <= gnt_id;
                    rsp_valid  <= 1'b1;
                end
                S_RESP: begin
                    // Priority rotates on completion, so a stalled response keeps it.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        last      <= gnt_id;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADDER_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_count    <= '0;
            stall_count <= '0;
        end else if (state == S_RESP) begin
            if (rsp_ready) op_count <= op_count + 32'd1;
            else stall_count <= stall_count + 32'd1;
        end
    end
`endif
endmodule
